reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_file_read_port.sv | 20 ++
 rtl/reg_file.sv | 68 ++++++
 tb/tb_reg_file.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared geometry constants for the RV32IM integer register file.
package reg_file_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_REGS   = 2 ** RF_ADDR_WIDTH;
  localparam int RF_X0_IDX     = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// One combinational read port: NUM_REGS:1 mux over the register contents, x0 forced to zero.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                    addr,
  output logic [DATA_WIDTH-1:0]                    data
);

  always_comb begin
    data = regs[addr];
    if (addr == ADDR_WIDTH'(RF_X0_IDX)) begin
      data = '0;
    end
  end

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// Integer register file: 32 x DATA_WIDTH, two combinational read ports, one clocked write port.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] WRITE_DATA,
  output logic [DATA_WIDTH-1:0] DATA1,
  output logic [DATA_WIDTH-1:0] DATA2,
  input  logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
  input  logic [ADDR_WIDTH-1:0] ADDRESS1,
  input  logic [ADDR_WIDTH-1:0] ADDRESS2,
  input  logic                  WRITE_ENABLE,
  input  logic                  CLK,
  input  logic                  RESET
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 wr_sel;

  // One-hot write decode; x0 is never selected so writes to it are dropped.
  always_comb begin
    wr_sel = '0;
    if (WRITE_ENABLE && (WRITE_ADDRESS != ADDR_WIDTH'(RF_X0_IDX))) begin
      wr_sel[WRITE_ADDRESS] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == RF_X0_IDX) begin : g_zero
      assign regs[gi] = '0;
    end else begin : g_store
      logic [DATA_WIDTH-1:0] q_reg;

      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          q_reg <= '0;
        end else if (wr_sel[gi]) begin
          q_reg <= WRITE_DATA;
        end
      end

      assign regs[gi] = q_reg;
    end
  end

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port1 (
    .regs (regs),
    .addr (ADDRESS1),
    .data (DATA1)
  );

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port2 (
    .regs (regs),
    .addr (ADDRESS2),
    .data (DATA2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file with hand-computed expected values.
module tb_reg_file;

  logic [31:0] write_data;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [4:0]  write_address;
  logic [4:0]  address1;
  logic [4:0]  address2;
  logic        write_enable;
  logic        clk;
  logic        reset;

  int checks = 0;
  int errors = 0;

  reg_file dut (
    .WRITE_DATA    (write_data),
    .DATA1         (data1),
    .DATA2         (data2),
    .WRITE_ADDRESS (write_address),
    .ADDRESS1      (address1),
    .ADDRESS2      (address2),
    .WRITE_ENABLE  (write_enable),
    .CLK           (clk),
    .RESET         (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Drive a write between edges, let one rising edge capture it, then drop the strobe.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic en);
    @(negedge clk);
    write_address = addr;
    write_data    = data;
    write_enable  = en;
    @(posedge clk);
    @(negedge clk);
    write_enable  = 1'b0;
  endtask

  task automatic read_both(input logic [4:0] a1, input logic [4:0] a2);
    address1 = a1;
    address2 = a2;
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    write_enable  = 1'b0;
    write_address = '0;
    write_data    = '0;
    address1      = 5'd0;
    address2      = 5'd31;
    #1;
    check("reset_data1_x0", data1, 32'd0);
    check("reset_data2_x31", data2, 32'd0);
    read_both(5'd1, 5'd17);
    check("reset_data1_x1", data1, 32'd0);
    check("reset_data2_x17", data2, 32'd0);

    @(negedge clk);
    reset = 1'b1;

    // Write x1 = 10; no bypass while the write is pending.
    write_address = 5'd1;
    write_data    = 32'd10;
    write_enable  = 1'b1;
    read_both(5'd1, 5'd0);
    check("pre_edge_x1", data1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    read_both(5'd1, 5'd0);
    check("write_x1", data1, 32'd10);

    do_write(5'd0, 32'd10, 1'b1);
    read_both(5'd1, 5'd0);
    check("x0_write_dropped", data2, 32'd0);

    do_write(5'd1, 32'hDEADBEEF, 1'b0);
    read_both(5'd1, 5'd0);
    check("we_low_keeps_x1", data1, 32'd10);

    do_write(5'd2, 32'd5, 1'b1);
    do_write(5'd3, 32'd7, 1'b1);
    read_both(5'd2, 5'd3);
    check("dual_read_x2", data1, 32'd5);
    check("dual_read_x3", data2, 32'd7);

    @(negedge clk);
    write_address = 5'd2;
    write_data    = 32'd9;
    write_enable  = 1'b1;
    read_both(5'd2, 5'd2);
    check("no_bypass_x2", data1, 32'd5);
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    read_both(5'd2, 5'd2);
    check("after_edge_x2_p1", data1, 32'd9);
    check("after_edge_x2_p2", data2, 32'd9);

    do_write(5'd31, 32'hFFFF_FFFF, 1'b1);
    read_both(5'd1, 5'd31);
    check("top_reg_x31", data2, 32'hFFFF_FFFF);
    check("x1_untouched", data1, 32'd10);

    // Asynchronous reset between edges with a write pending.
    @(negedge clk);
    write_address = 5'd1;
    write_data    = 32'h55;
    write_enable  = 1'b1;
    reset         = 1'b0;
    read_both(5'd1, 5'd31);
    check("async_reset_x1", data1, 32'd0);
    check("async_reset_x31", data2, 32'd0);
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    read_both(5'd1, 5'd3);
    check("write_in_reset_lost", data1, 32'd0);
    check("reset_clears_x3", data2, 32'd0);
    reset = 1'b1;
    #1;
    check("post_reset_x1", data1, 32'd0);

    do_write(5'd4, 32'h1234_5678, 1'b1);
    read_both(5'd4, 5'd1);
    check("first_write_after_reset", data1, 32'h1234_5678);
    check("x1_still_zero", data2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: got no finish expected finish within 5000ns");
    $fatal(1, "timeout");
  end

endmodule : tb_reg_file
